// File: rtl/uart_tx_fifo.sv
// Buffered 8N1/8E1/8O1 (1 or 2 stop bits) UART transmitter fed through a
// valid/ready write port into a power-of-two FIFO; frames go out back-to-back.
module uart_tx_fifo #(
  parameter int CLOCKS_PER_BIT = 2604,
  parameter int FIFO_ADDR_BITS = 4,
  parameter int PARITY_EN      = 0,
  parameter int PARITY_ODD     = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [7:0]              wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic                    TXD,
  output logic                    busy,
  output logic                    tx_done,
  output logic [FIFO_ADDR_BITS:0] fifo_count
);

  localparam int DEPTH = 1 << FIFO_ADDR_BITS;
  localparam int TW    = $clog2(CLOCKS_PER_BIT);
  localparam logic [TW-1:0]           LAST_TICK = TW'(CLOCKS_PER_BIT - 1);
  localparam logic [FIFO_ADDR_BITS:0] FULL      = (FIFO_ADDR_BITS + 1)'(DEPTH);
  localparam logic                    LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic                    ODD       = 1'(PARITY_ODD);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                    state_q, state_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic [2:0]                idx_q, idx_d;
  logic                      stop_q, stop_d;
  logic [7:0]                shift_q, shift_d;
  logic                      txd_q, txd_d;
  logic                      done_q, done_d;
  logic [7:0]                mem_q [DEPTH];
  logic [FIFO_ADDR_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_ADDR_BITS:0]   count_q;
  logic                      push, pop, tick, fifo_empty;

  // Full test uses the registered count, so a pop in the same cycle never frees a slot early.
  assign wr_ready   = reset_n & (count_q != FULL);
  assign push       = wr_valid & wr_ready;
  assign fifo_empty = (count_q == '0);
  assign tick       = (timer_q == LAST_TICK);

  assign TXD        = txd_q;
  assign tx_done    = done_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) | ~fifo_empty;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = tick ? '0 : timer_q + 1'b1;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    txd_d   = 1'b1;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = START;
        end
      end
      START: begin
        txd_d = 1'b0;
        if (tick) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        txd_d = shift_q[idx_q];
        if (tick) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == 3'd7) begin
            stop_d  = 1'b0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        txd_d = (^shift_q) ^ ODD;
        if (tick) begin
          stop_d  = 1'b0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_q == LAST_STOP) begin
            done_d = 1'b1;
            // Chain straight into the next start bit when more data is queued.
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = mem_q[rd_ptr_q];
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // TXD and tx_done are registered, so both trail the state register by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances (8N1, 8E1, 8O1, 8N2) at 4 clocks/bit,
// a line decoder/scoreboard per instance, a vector table and hand sequences.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] wr_data;
  logic       wr_valid [4];
  logic       rdy [4];
  logic       txd [4];
  logic       busy [4];
  logic       done [4];
  logic [4:0] cnt [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLOCKS_PER_BIT(4)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .wr_data(wr_data), .wr_valid(wr_valid[0]),
    .wr_ready(rdy[0]), .TXD(txd[0]), .busy(busy[0]), .tx_done(done[0]), .fifo_count(cnt[0]));
  uart_tx_fifo #(.CLOCKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .wr_data(wr_data), .wr_valid(wr_valid[1]),
    .wr_ready(rdy[1]), .TXD(txd[1]), .busy(busy[1]), .tx_done(done[1]), .fifo_count(cnt[1]));
  uart_tx_fifo #(.CLOCKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .wr_data(wr_data), .wr_valid(wr_valid[2]),
    .wr_ready(rdy[2]), .TXD(txd[2]), .busy(busy[2]), .tx_done(done[2]), .fifo_count(cnt[2]));
  uart_tx_fifo #(.CLOCKS_PER_BIT(4), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .wr_data(wr_data), .wr_valid(wr_valid[3]),
    .wr_ready(rdy[3]), .TXD(txd[3]), .busy(busy[3]), .tx_done(done[3]), .fifo_count(cnt[3]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Frame format per instance, straight from the line rules.
  function automatic int nbits(input int k);
    return (k == 0) ? 10 : 11;
  endfunction
  function automatic bit has_par(input int k);
    return (k == 1) || (k == 2);
  endfunction
  function automatic bit is_odd(input int k);
    return k == 2;
  endfunction

  // Scoreboard: accepted bytes in order, and a line decoder per instance.
  int         pos [4] = '{-1, -1, -1, -1};
  int         rp [4]  = '{0, 0, 0, 0};
  int         wp [4]  = '{0, 0, 0, 0};
  int         nfr [4] = '{0, 0, 0, 0};
  logic [7:0] lastb [4];
  logic       samp [4][64];
  logic [7:0] exb [4][256];

  task automatic frame_end(input int k);
    logic [7:0] b;
    bit ok;
    int np;
    ok = 1'b1;
    np = has_par(k) ? 1 : 0;
    for (int j = 0; j < nbits(k); j++)
      for (int s = 1; s < 4; s++)
        if (samp[k][j*4+s] !== samp[k][j*4]) ok = 1'b0;
    if (samp[k][0] !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) b[i] = samp[k][(1+i)*4];
    if (np == 1 && samp[k][36] !== ((^b) ^ is_odd(k))) ok = 1'b0;
    for (int j = 9 + np; j < nbits(k); j++)
      if (samp[k][j*4] !== 1'b1) ok = 1'b0;
    chk($sformatf("frame_shape[%0d]", k), ok, 1);
    chk($sformatf("frame_expected[%0d]", k), rp[k] != wp[k], 1);
    if (rp[k] != wp[k]) begin
      chk($sformatf("frame_byte[%0d]", k), b, exb[k][rp[k] % 256]);
      rp[k]++;
    end
    lastb[k] = b;
    nfr[k]++;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!reset_n) begin
        pos[k] = -1;
        rp[k]  = 0;
        wp[k]  = 0;
      end else begin
        if (wr_valid[k] && rdy[k]) begin
          exb[k][wp[k] % 256] = wr_data;
          wp[k]++;
        end
        if (pos[k] >= 0 || txd[k] == 1'b0) begin
          if (pos[k] < 0) pos[k] = 0;
          samp[k][pos[k]] = txd[k];
          if (pos[k] == nbits(k) * 4 - 1) begin
            chk($sformatf("tx_done_end[%0d]", k), done[k], 1);
            frame_end(k);
            pos[k] = -1;
          end else begin
            chk($sformatf("tx_done_mid[%0d]", k), done[k], 0);
            pos[k]++;
          end
        end else begin
          chk($sformatf("tx_done_idle[%0d]", k), done[k], 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int k, input int bound);
    int n;
    n = 0;
    while ((busy[k] !== 1'b0 || rp[k] != wp[k] || pos[k] >= 0) && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk($sformatf("drain_in_time[%0d]", k), n < bound, 1);
  endtask

  typedef struct {
    logic       vld;
    logic [7:0] data;
    logic       txd;
    logic       busy;
    logic       done;
    logic [4:0] cnt;
  } vec_t;

  // 0x55 on the 8N1 instance; row r is checked in the cycle after edge r-1 of acceptance.
  task automatic test1();
    vec_t tv [44];
    logic [7:0] b;
    int c;
    b = 8'h55;
    for (int r = 0; r < 44; r++) begin
      c = r - 1;
      tv[r].vld  = (r == 0);
      tv[r].data = (r == 0) ? b : 8'h00;
      tv[r].cnt  = (c == 0) ? 5'd1 : 5'd0;
      tv[r].busy = (c >= 0) && (c <= 40);
      tv[r].done = (c == 41);
      if (c < 2)       tv[r].txd = 1'b1;
      else if (c < 6)  tv[r].txd = 1'b0;
      else if (c < 38) tv[r].txd = b[(c-6)/4];
      else             tv[r].txd = 1'b1;
    end
    for (int r = 0; r < 44; r++) begin
      wr_valid[0] = tv[r].vld;
      wr_data     = tv[r].data;
      @(negedge clk);
      chk($sformatf("vec%0d{txd,busy,done,cnt}", r), {txd[0], busy[0], done[0], cnt[0]},
          {tv[r].txd, tv[r].busy, tv[r].done, tv[r].cnt});
      tick();
    end
    wr_valid[0] = 1'b0;
    wait_drain(0, 50);
    chk("t1_frames", nfr[0], 1);
  endtask

  task automatic test2();
    wr_valid[1] = 1'b1;
    wr_valid[2] = 1'b1;
    wr_data     = 8'hA3;
    tick();
    wr_valid[1] = 1'b0;
    wr_valid[2] = 1'b0;
    for (int c = 0; c <= 47; c++) begin
      @(negedge clk);
      if (c == 39) begin
        chk("parity_even_bit", txd[1], 0);
        chk("parity_odd_bit", txd[2], 1);
      end
      chk($sformatf("parity_done_c%0d", c), {done[1], done[2]}, (c == 45) ? 2'b11 : 2'b00);
    end
    wait_drain(1, 50);
    wait_drain(2, 50);
  endtask

  task automatic test3();
    int nd;
    int t [3];
    nd = 0;
    wr_valid[3] = 1'b1;
    wr_data = 8'h01;
    tick();
    wr_data = 8'h80;
    tick();
    wr_data = 8'hFF;
    tick();
    wr_valid[3] = 1'b0;
    for (int c = 2; c <= 150; c++) begin
      @(negedge clk);
      if (done[3]) begin
        if (nd < 3) t[nd] = c;
        nd++;
      end
    end
    chk("burst_done_count", nd, 3);
    if (nd >= 3) begin
      chk("burst_done0", t[0], 45);
      chk("burst_done1", t[1], 89);
      chk("burst_done2", t[2], 133);
    end
    wait_drain(3, 50);
  endtask

  task automatic test4();
    int acc, maxc, n, f0;
    acc = 0; maxc = 0; n = 0; f0 = nfr[0];
    wr_valid[0] = 1'b1;
    wr_data = 8'($urandom);
    while (acc < 20 && n < 400) begin
      @(negedge clk);
      chk("wr_ready_vs_count", rdy[0], cnt[0] != 5'd16);
      if (int'(cnt[0]) > maxc) maxc = int'(cnt[0]);
      if (rdy[0]) acc++;
      tick();
      n++;
      if (acc >= 20) wr_valid[0] = 1'b0;
      else if (rdy[0] === 1'b0 && n > 0) ;
      else wr_data = 8'($urandom);
    end
    wr_valid[0] = 1'b0;
    chk("fill_accepted", acc, 20);
    chk("fill_max_count", maxc, 16);
    wait_drain(0, 1500);
    chk("fill_frames", nfr[0] - f0, 20);
  endtask

  task automatic test5();
    int f0;
    wr_valid[0] = 1'b1;
    wr_data = 8'h0F;
    tick();
    wr_data = 8'h33;
    tick();
    wr_valid[0] = 1'b0;
    repeat (27) @(negedge clk);
    chk("pre_reset_txd_d5", txd[0], 0);
    chk("pre_reset_count", cnt[0], 1);
    #1 reset_n = 1'b0;
    #1 chk("async_reset{txd,busy,done,rdy,cnt}", {txd[0], busy[0], done[0], rdy[0], cnt[0]},
           {1'b1, 1'b0, 1'b0, 1'b0, 5'd0});
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1 chk("ready_after_release", rdy[0], 1);
    tick();
    f0 = nfr[0];
    wr_valid[0] = 1'b1;
    wr_data = 8'h42;
    tick();
    wr_valid[0] = 1'b0;
    wait_drain(0, 200);
    chk("post_reset_frames", nfr[0] - f0, 1);
    chk("post_reset_byte", lastb[0], 8'h42);
  endtask

  task automatic test6();
    int f0, acc, n;
    f0 = nfr[0];
    for (int i = 0; i < 6; i++) begin
      wr_valid[0] = 1'b1;
      wr_data = 8'($urandom);
      tick();
    end
    wr_valid[0] = 1'b0;
    @(negedge clk);
    chk("count_five", cnt[0], 5);
    repeat (34) @(negedge clk);
    tick();
    wr_valid[0] = 1'b1;
    wr_data = 8'($urandom);
    @(negedge clk);
    chk("count_before_pushpop", cnt[0], 5);
    chk("no_done_before_pushpop", done[0], 0);
    tick();
    wr_valid[0] = 1'b0;
    @(negedge clk);
    chk("count_after_pushpop", cnt[0], 5);
    chk("pop_at_frame_end", done[0], 1);
    tick();
    acc = 0;
    n = 0;
    while (acc < 40 && n < 6000) begin
      wr_valid[0] = 1'($urandom_range(0, 1));
      wr_data = 8'($urandom);
      @(negedge clk);
      if (wr_valid[0] && rdy[0]) acc++;
      tick();
      n++;
    end
    wr_valid[0] = 1'b0;
    chk("wrap_writes", acc, 40);
    wait_drain(0, 4000);
    chk("wrap_frames", nfr[0] - f0, 47);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    wr_data = 8'h00;
    for (int k = 0; k < 4; k++) wr_valid[k] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++)
      chk($sformatf("reset{txd,busy,done,rdy,cnt}[%0d]", k), {txd[k], busy[k], done[k], rdy[k], cnt[k]},
          {1'b1, 1'b0, 1'b0, 1'b0, 5'd0});
    tick();
    reset_n = 1'b1;
    #1 chk("ready_after_reset", rdy[0], 1);
    tick();
    test1();
    tick();
    test2();
    tick();
    test3();
    tick();
    test4();
    tick();
    test5();
    tick();
    test6();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
